// File: rtl/up_down_counter_mc_if.sv
// AXI4-Lite channel bundle between the PS interconnect and the multi-channel counter.
// The master modport drives requests; the slave modport drives ready and response signals.
interface up_down_counter_mc_if #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0]   awaddr;
  logic [2:0]              awprot;
  logic                    awvalid;
  logic                    awready;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    wvalid;
  logic                    wready;
  logic [1:0]              bresp;
  logic                    bvalid;
  logic                    bready;
  logic [ADDR_WIDTH-1:0]   araddr;
  logic [2:0]              arprot;
  logic                    arvalid;
  logic                    arready;
  logic [DATA_WIDTH-1:0]   rdata;
  logic [1:0]              rresp;
  logic                    rvalid;
  logic                    rready;

  modport master (
    output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
           araddr, arprot, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
           araddr, arprot, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/up_down_counter_mc.sv
// AXI4-Lite slave with NUM_CH up/down counters (enable, direction, wrap/saturate, load, compare match).
// Optional UDC_IRQ_EN adds an irq port plus IRQ_STAT/IRQ_MASK at NUM_CH*0x10.
module up_down_counter_mc #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 8,
    parameter int NUM_CH             = 4,
    parameter int CNT_WIDTH          = 16
) (
    input  logic                        ACLK,
    input  logic                        ARESETN,
    up_down_counter_mc_if.slave         s_axi,
    input  logic [NUM_CH-1:0]           cnt_ce,
    output logic [NUM_CH*CNT_WIDTH-1:0] cnt_value,
    output logic [NUM_CH-1:0]           cnt_match
`ifdef UDC_IRQ_EN
    ,
    output logic                        irq
`endif
);

  localparam int IDX_W = C_S_AXI_ADDR_WIDTH - 4;
  localparam logic [CNT_WIDTH-1:0] CMAX = '1;
  localparam logic [CNT_WIDTH-1:0] ONE  = CNT_WIDTH'(1);

  logic [CNT_WIDTH-1:0] cnt_q  [NUM_CH];
  logic [CNT_WIDTH-1:0] load_q [NUM_CH];
  logic [CNT_WIDTH-1:0] cmp_q  [NUM_CH];
  logic [2:0]           ctrl_q [NUM_CH];  // {SAT, DIR, EN}

  logic [CNT_WIDTH-1:0] cnt_nxt  [NUM_CH];
  logic [CNT_WIDTH-1:0] load_new [NUM_CH];
  logic [CNT_WIDTH-1:0] cmp_new  [NUM_CH];
  logic [NUM_CH-1:0]    cnt_upd;
  logic [NUM_CH-1:0]    ld_now;
  logic [NUM_CH-1:0]    wr_ctrl, wr_load, wr_cmp;

  logic                 wr_fire, rd_fire;
  logic [IDX_W-1:0]     wr_idx, rd_idx;
  logic [1:0]           wr_off, rd_off;
  logic [31:0]          wr_mask;
  logic [CNT_WIDTH-1:0] wr_mask_c;
  logic                 wr_err, rd_err;
  logic [31:0]          rd_dat;

`ifdef UDC_IRQ_EN
  logic [NUM_CH-1:0]    irq_stat, irq_mask, stat_clr, mask_new;
  logic                 wr_stat, wr_imask;
`endif

  logic unused_ok;
  assign unused_ok = ^{s_axi.awprot, s_axi.arprot, s_axi.awaddr[1:0], s_axi.araddr[1:0],
                       s_axi.wdata, wr_mask};

  assign wr_fire   = s_axi.awready & s_axi.awvalid & s_axi.wvalid;
  assign rd_fire   = s_axi.arready & s_axi.arvalid;
  assign wr_idx    = s_axi.awaddr[C_S_AXI_ADDR_WIDTH-1:4];
  assign wr_off    = s_axi.awaddr[3:2];
  assign rd_idx    = s_axi.araddr[C_S_AXI_ADDR_WIDTH-1:4];
  assign rd_off    = s_axi.araddr[3:2];
  assign wr_mask   = {{8{s_axi.wstrb[3]}}, {8{s_axi.wstrb[2]}},
                      {8{s_axi.wstrb[1]}}, {8{s_axi.wstrb[0]}}};
  assign wr_mask_c = wr_mask[CNT_WIDTH-1:0];

  genvar g;
  generate
    for (g = 0; g < NUM_CH; g++) begin : g_out
      assign cnt_value[g*CNT_WIDTH +: CNT_WIDTH] = cnt_q[g];
    end
  endgenerate

  // Write decode and next-count selection; a load always wins over a step.
  always_comb begin
    wr_err = 1'b1;
    if (int'(wr_idx) < NUM_CH) wr_err = 1'b0;
`ifdef UDC_IRQ_EN
    wr_stat  = wr_fire && (int'(wr_idx) == NUM_CH) && (wr_off == 2'd0);
    wr_imask = wr_fire && (int'(wr_idx) == NUM_CH) && (wr_off == 2'd1);
    if ((int'(wr_idx) == NUM_CH) && !wr_off[1]) wr_err = 1'b0;
    stat_clr = s_axi.wdata[NUM_CH-1:0] & wr_mask[NUM_CH-1:0];
    mask_new = (irq_mask & ~wr_mask[NUM_CH-1:0]) | stat_clr;
`endif
    for (int n = 0; n < NUM_CH; n++) begin
      wr_ctrl[n]  = wr_fire && (int'(wr_idx) == n) && (wr_off == 2'd0);
      wr_load[n]  = wr_fire && (int'(wr_idx) == n) && (wr_off == 2'd1);
      wr_cmp[n]   = wr_fire && (int'(wr_idx) == n) && (wr_off == 2'd3);
      ld_now[n]   = wr_ctrl[n] && s_axi.wstrb[0] && s_axi.wdata[3];
      load_new[n] = (load_q[n] & ~wr_mask_c) | (s_axi.wdata[CNT_WIDTH-1:0] & wr_mask_c);
      cmp_new[n]  = (cmp_q[n] & ~wr_mask_c) | (s_axi.wdata[CNT_WIDTH-1:0] & wr_mask_c);

      cnt_nxt[n] = cnt_q[n];
      cnt_upd[n] = 1'b0;
      if (ld_now[n]) begin
        cnt_nxt[n] = load_q[n];
        cnt_upd[n] = 1'b1;
      end else if (ctrl_q[n][0] && cnt_ce[n]) begin
        if (!ctrl_q[n][1]) begin
          if (cnt_q[n] != CMAX) begin
            cnt_nxt[n] = cnt_q[n] + ONE;
            cnt_upd[n] = 1'b1;
          end else if (!ctrl_q[n][2]) begin
            cnt_nxt[n] = '0;
            cnt_upd[n] = 1'b1;
          end
        end else begin
          if (cnt_q[n] != '0) begin
            cnt_nxt[n] = cnt_q[n] - ONE;
            cnt_upd[n] = 1'b1;
          end else if (!ctrl_q[n][2]) begin
            cnt_nxt[n] = CMAX;
            cnt_upd[n] = 1'b1;
          end
        end
      end
    end
  end

  // Read mux; COUNT is captured from the register in the ARREADY cycle.
  always_comb begin
    rd_dat = '0;
    rd_err = 1'b1;
    for (int n = 0; n < NUM_CH; n++) begin
      if (int'(rd_idx) == n) begin
        rd_err = 1'b0;
        case (rd_off)
          2'd0:    rd_dat = {29'd0, ctrl_q[n]};
          2'd1:    rd_dat = 32'(load_q[n]);
          2'd2:    rd_dat = 32'(cnt_q[n]);
          default: rd_dat = 32'(cmp_q[n]);
        endcase
      end
    end
`ifdef UDC_IRQ_EN
    if ((int'(rd_idx) == NUM_CH) && !rd_off[1]) begin
      rd_err = 1'b0;
      rd_dat = rd_off[0] ? 32'(irq_mask) : 32'(irq_stat);
    end
`endif
  end

  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      s_axi.awready <= 1'b0;
      s_axi.wready  <= 1'b0;
      s_axi.bvalid  <= 1'b0;
      s_axi.bresp   <= 2'b00;
      s_axi.arready <= 1'b0;
      s_axi.rvalid  <= 1'b0;
      s_axi.rresp   <= 2'b00;
      s_axi.rdata   <= '0;
      cnt_match     <= '0;
      for (int n = 0; n < NUM_CH; n++) begin
        cnt_q[n]  <= '0;
        load_q[n] <= '0;
        cmp_q[n]  <= '0;
        ctrl_q[n] <= '0;
      end
`ifdef UDC_IRQ_EN
      irq_stat <= '0;
      irq_mask <= '0;
      irq      <= 1'b0;
`endif
    end else begin
      s_axi.awready <= s_axi.awvalid & s_axi.wvalid & ~s_axi.bvalid & ~s_axi.awready;
      s_axi.wready  <= s_axi.awvalid & s_axi.wvalid & ~s_axi.bvalid & ~s_axi.awready;
      if (wr_fire) begin
        s_axi.bvalid <= 1'b1;
        s_axi.bresp  <= wr_err ? 2'b10 : 2'b00;
      end else if (s_axi.bready) begin
        s_axi.bvalid <= 1'b0;
      end

      s_axi.arready <= s_axi.arvalid & ~s_axi.rvalid & ~s_axi.arready;
      if (rd_fire) begin
        s_axi.rvalid <= 1'b1;
        s_axi.rdata  <= rd_dat;
        s_axi.rresp  <= rd_err ? 2'b10 : 2'b00;
      end else if (s_axi.rready) begin
        s_axi.rvalid <= 1'b0;
      end

      for (int n = 0; n < NUM_CH; n++) begin
        if (wr_ctrl[n] && s_axi.wstrb[0]) ctrl_q[n] <= s_axi.wdata[2:0];
        if (wr_load[n]) load_q[n] <= load_new[n];
        if (wr_cmp[n])  cmp_q[n]  <= cmp_new[n];
        cnt_q[n]     <= cnt_nxt[n];
        cnt_match[n] <= cnt_upd[n] && (cnt_nxt[n] == cmp_q[n]);
      end
`ifdef UDC_IRQ_EN
      // New match events take priority over a same-cycle W1C.
      irq_stat <= (wr_stat ? (irq_stat & ~stat_clr) : irq_stat) | cnt_match;
      if (wr_imask) irq_mask <= mask_new;
      irq <= |(irq_stat & irq_mask);
`endif
    end
  end

endmodule
